sram_access_arbiter: RTL and testbench

- Sequences and shares the single 2K x 8 SRAM (11-bit address, 8-bit bidirectional data, enable, read/write) between two requesters.
  - Requester 0: the processor-side PIO bridge.
  - Requester 1: game hardware, e.g. sprite/alien state writer or display scanner.
- Grants one access at a time with round-robin priority.
- Generates the SRAM control timing, owns the tri-state data bus, and returns read data with a one-cycle done pulse.

---
 rtl/sram_access_arbiter_if.sv | 46 ++++
 rtl/sram_access_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_access_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_arbiter_if.sv
// Requester handshake and SRAM control signals shared by sram_access_arbiter and its users.
// SRAM_ARB_STATS_EN adds the per-requester grant counters.
interface sram_access_arbiter_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 8
);
   logic              req0;
   logic              write0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              done0;
   logic              req1;
   logic              write1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              done1;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic [ADDR_W-1:0] sram_address;
   logic              sram_enable;
   logic              sram_read_write;
`ifdef SRAM_ARB_STATS_EN
   logic [15:0]       grant_count0;
   logic [15:0]       grant_count1;

   modport master (
      output req0, write0, addr0, wdata0, req1, write1, addr1, wdata1,
      input  done0, done1, rdata, busy, sram_address, sram_enable, sram_read_write,
      input  grant_count0, grant_count1
   );
   modport slave (
      input  req0, write0, addr0, wdata0, req1, write1, addr1, wdata1,
      output done0, done1, rdata, busy, sram_address, sram_enable, sram_read_write,
      output grant_count0, grant_count1
   );
`else
   modport master (
      output req0, write0, addr0, wdata0, req1, write1, addr1, wdata1,
      input  done0, done1, rdata, busy, sram_address, sram_enable, sram_read_write
   );
   modport slave (
      input  req0, write0, addr0, wdata0, req1, write1, addr1, wdata1,
      output done0, done1, rdata, busy, sram_address, sram_enable, sram_read_write
   );
`endif
endinterface

// File: rtl/sram_access_arbiter.sv
// Round-robin two-requester arbiter and access sequencer for a single 2K x 8 SRAM.
// Define SRAM_ARB_STATS_EN to add saturating per-requester grant counters.
module sram_access_arbiter #(
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   sram_access_arbiter_if.slave   bus,
   inout  wire  [DATA_W-1:0]      sram_data
);
   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSetup  = 2'd1;
   localparam logic [1:0] StAccess = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              any_req;
   logic              gnt;
   logic              active;

   assign any_req = bus.req0 | bus.req1;
   // On a tie the requester that did not win last time goes first.
   assign gnt     = (bus.req0 & bus.req1) ? ~last_grant_q : bus.req1;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      case (state_q)
         StIdle: begin
            if (any_req) begin
               grant_d      = gnt;
               last_grant_d = gnt;
               write_d      = gnt ? bus.write1 : bus.write0;
               addr_d       = gnt ? bus.addr1  : bus.addr0;
               wdata_d      = gnt ? bus.wdata1 : bus.wdata0;
               state_d      = StSetup;
            end
         end
         StSetup: begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = StAccess;
         end
         StAccess: begin
            if (cnt_q == '0) begin
               if (!write_q) rdata_d = sram_data;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   // Enable and write direction come straight from state, so DONE is the bus turnaround cycle.
   assign active              = (state_q == StSetup) | (state_q == StAccess);
   assign bus.sram_enable     = active;
   assign bus.sram_read_write = ~(active & write_q);
   assign bus.sram_address    = addr_q;
   assign sram_data           = (active & write_q) ? wdata_q : {DATA_W{1'bz}};
   assign bus.done0           = (state_q == StDone) & ~grant_q;
   assign bus.done1           = (state_q == StDone) & grant_q;
   assign bus.busy            = (state_q != StIdle);
   assign bus.rdata           = rdata_q;

`ifdef SRAM_ARB_STATS_EN
   logic [15:0] gc0_q, gc1_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         gc0_q <= '0;
         gc1_q <= '0;
      end else if (state_q == StIdle && any_req) begin
         if (!gnt && gc0_q != 16'hFFFF) gc0_q <= gc0_q + 16'd1;
         if (gnt && gc1_q != 16'hFFFF)  gc1_q <= gc1_q + 16'd1;
      end
   end

   assign bus.grant_count0 = gc0_q;
   assign bus.grant_count1 = gc1_q;
`endif
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: SRAM model, done-event scoreboard, bus-timing checks.
module tb_sram_access_arbiter;
   localparam int unsigned AW = 11;
   localparam int unsigned DW = 8;
   localparam int unsigned W  = 2;
   // Value the SRAM model parks on the bus whenever the arbiter must not drive it.
   localparam logic [DW-1:0] IdlePat = 8'h00;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   wire [DW-1:0] sram_data;

   sram_access_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .WAIT_CYCLES (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .sram_data (sram_data)
   );

   logic [DW-1:0] mem [0:2047];
   assign sram_data = !bus.sram_enable ? IdlePat :
                      bus.sram_read_write ? mem[bus.sram_address] : {DW{1'bz}};
   always @(posedge clk)
      if (bus.sram_enable && !bus.sram_read_write) mem[bus.sram_address] <= sram_data;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit            id;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] last_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit id, input bit v, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (id) begin
         bus.req1 = v; bus.write1 = wr; bus.addr1 = a; bus.wdata1 = d;
      end else begin
         bus.req0 = v; bus.write0 = wr; bus.addr0 = a; bus.wdata0 = d;
      end
   endtask

   task automatic push(input bit id, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int dcyc);
      exp_t e;
      e.id = id; e.wr = wr; e.addr = a; e.wdata = d; e.cyc = dcyc;
      if (!wr) last_rdata = mem[a];
      e.rdata = last_rdata;
      sb.push_back(e);
   endtask

   // Call right after a posedge+1 while the arbiter is idle.
   task automatic issue(input bit id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      set_req(id, 1'b1, wr, a, d);
      push(id, wr, a, d, cyc + 2 + int'(W));
   endtask

   task automatic wait_done(input bit chk_en);
      exp_t          e;
      bit            got = 1'b0;
      int            en_cnt = 0;
      logic [DW-1:0] bexp;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.sram_enable && sb.size() > 0) begin
            e = sb[0];
            en_cnt++;
            chk("sram_address", 32'(bus.sram_address), 32'(e.addr));
            chk("sram_rw", 32'(bus.sram_read_write), 32'(!e.wr));
            bexp = e.wr ? e.wdata : mem[e.addr];
            chk("sram_data", 32'(sram_data), 32'(bexp));
         end else if (!bus.sram_enable) begin
            chk("idle_rw", 32'(bus.sram_read_write), 32'd1);
            chk("idle_bus", 32'(sram_data), 32'(IdlePat));
         end
         if (bus.done0 || bus.done1) got = 1'b1;
      end
      chk("done_seen", 32'(got), 32'd1);
      if (got) begin
         chk("one_done", 32'(bus.done0 & bus.done1), 32'd0);
         chk("sb_pending", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_id", 32'(bus.done1), 32'(e.id));
            chk("done_cyc", 32'(cyc), 32'(e.cyc));
            chk("rdata", 32'(bus.rdata), 32'(e.rdata));
            if (chk_en) chk("en_cycles", 32'(en_cnt), 32'(W + 1));
         end
      end
   endtask

   initial begin
      int base;
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      set_req(1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1'b1, 1'b0, 1'b0, '0, '0);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      last_rdata = '0;

      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_en", 32'(bus.sram_enable), 32'd0);
      chk("rst_rw", 32'(bus.sram_read_write), 32'd1);
      chk("rst_addr", 32'(bus.sram_address), 32'd0);
      chk("rst_bus", 32'(sram_data), 32'(IdlePat));
`ifdef SRAM_ARB_STATS_EN
      chk("rst_gc0", 32'(bus.grant_count0), 32'd0);
      chk("rst_gc1", 32'(bus.grant_count1), 32'd0);
`endif

      // Single write, read back, then two more requester-0 accesses.
      tick(1); issue(1'b0, 1'b1, 11'h123, 8'hA5); wait_done(1'b1); bus.req0 = 1'b0;
      tick(1); issue(1'b1, 1'b0, 11'h123, 8'h00); wait_done(1'b1); bus.req1 = 1'b0;
      tick(1); issue(1'b0, 1'b1, 11'h7FF, 8'h3C); wait_done(1'b1); bus.req0 = 1'b0;
      tick(1); issue(1'b0, 1'b0, 11'h7FF, 8'h00); wait_done(1'b1); bus.req0 = 1'b0;
      chk("rb_rdata", 32'(bus.rdata), 32'h3C);
`ifdef SRAM_ARB_STATS_EN
      chk("gc0_3", 32'(bus.grant_count0), 32'd3);
      chk("gc1_1", 32'(bus.grant_count1), 32'd1);
`endif

      // A one-cycle req0 pulse while requester 1 is being served must be ignored.
      tick(1); issue(1'b1, 1'b1, 11'h050, 8'h77);
      tick(1); set_req(1'b0, 1'b1, 1'b1, 11'h051, 8'h99);
      tick(1); bus.req0 = 1'b0;
      wait_done(1'b0); bus.req1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("drop_busy", 32'(bus.busy), 32'd0);
         chk("drop_done0", 32'(bus.done0), 32'd0);
      end
      chk("drop_mem", 32'(mem[11'h051]), 32'd0);

      // Reset during ACCESS of a write.
      tick(1); set_req(1'b0, 1'b1, 1'b1, 11'h200, 8'h5A);
      tick(2);
      reset = 1'b1;
      bus.req0 = 1'b0;
      @(negedge clk);
      chk("mid_en", 32'(bus.sram_enable), 32'd1);
      tick(1);
      reset = 1'b0;
      last_rdata = '0;
      @(negedge clk);
      chk("mid_en_off", 32'(bus.sram_enable), 32'd0);
      chk("mid_bus", 32'(sram_data), 32'(IdlePat));
      chk("mid_busy", 32'(bus.busy), 32'd0);
      chk("mid_rdata", 32'(bus.rdata), 32'd0);
      chk("mid_rw", 32'(bus.sram_read_write), 32'd1);
`ifdef SRAM_ARB_STATS_EN
      chk("mid_gc0", 32'(bus.grant_count0), 32'd0);
      chk("mid_gc1", 32'(bus.grant_count1), 32'd0);
`endif
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("mid_no_done0", 32'(bus.done0), 32'd0);
      end

      // Both requesters held from reset release: alternate 0,1,0,1 every 3+W cycles.
      tick(1);
      reset = 1'b1;
      set_req(1'b0, 1'b1, 1'b1, 11'h010, 8'h11);
      set_req(1'b1, 1'b1, 1'b1, 11'h020, 8'h22);
      tick(1);
      reset = 1'b0;
      last_rdata = '0;
      base = cyc + 2 + int'(W);
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) push(1'b0, 1'b1, 11'h010, 8'h11, base + k * int'(3 + W));
         else            push(1'b1, 1'b1, 11'h020, 8'h22, base + k * int'(3 + W));
      end
      for (int k = 0; k < 4; k++) wait_done(1'b1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
